// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I instruction sequencer: owns pc and the instruction register,
// fetches over a req/ack port and steps each instruction FETCH->DECODE->EXEC->WB.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    input  logic                ctl_reg_write_en,
    output logic                rf_we,
    output logic [31:0]         pc,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

    state_e              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                opcodeLegal;

    assign opcodeLegal = (instr_q[6:0] == OPC_OP) || (instr_q[6:0] == OPC_OP_IMM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // run is only looked at in IDLE and WB, so an instruction in flight always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH:   if (imem_ack) state_d = DECODE;
            DECODE:  state_d = opcodeLegal ? EXEC : HALT;
            EXEC:    state_d = WB;
            WB:      state_d = run ? FETCH : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        if (state_q == FETCH && imem_ack) begin
            instr_d = imem_rdata;
        end
        if (state_q == WB) begin
            pc_d      = pc_q + 32'd4;
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Strobes decode from the registered state only, so reset drops them without a clock edge.
    always_comb begin
        imem_req = (state_q == FETCH);
        rf_we    = (state_q == WB) && ctl_reg_write_en;
        halted   = (state_q == HALT);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven instruction vectors with a
// WB-time scoreboard, hand sequences for halt/run-drop/reset, and a wrap instance.
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        run;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ctl_reg_write_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        rf_we;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired;
    logic [2:0]  state;

    logic        w_rst_n;
    logic        w_run;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_instr;
    logic        w_rf_we;
    logic [31:0] w_pc;
    logic        w_halted;
    logic [3:0]  w_retired;
    logic [2:0]  w_state;

    instr_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .ctl_reg_write_en (ctl_reg_write_en),
        .rf_we            (rf_we),
        .pc               (pc),
        .halted           (halted),
        .retired          (retired),
        .state            (state)
    );

    instr_sequencer #(
        .RESET_PC (32'hFFFF_FFFC),
        .RETIRE_W (4)
    ) u_wrap (
        .clk              (clk),
        .rst_n            (w_rst_n),
        .run              (w_run),
        .imem_req         (w_imem_req),
        .imem_addr        (w_imem_addr),
        .imem_ack         (1'b1),
        .imem_rdata       (32'h0000_0013),
        .instr            (w_instr),
        .ctl_reg_write_en (1'b1),
        .rf_we            (w_rf_we),
        .pc               (w_pc),
        .halted           (w_halted),
        .retired          (w_retired),
        .state            (w_state)
    );

    typedef struct {
        logic [31:0] word;
        int          ackWait;
        logic        ctlWe;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        rfWe;
    } sbItem_t;

    sbItem_t     sbQueue[$];
    sbItem_t     sbItem;
    vec_t        vecs[5];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelPc;
    logic [31:0] modelRetired;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every WB cycle must match the oldest fetched legal instruction; rf_we never outside WB.
    always @(negedge clk) begin
        if (rst_n) begin
            if (state == 3'd4) begin
                if (sbQueue.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected_wb: got WB with pc %h expected no WB", pc);
                end else begin
                    sbItem = sbQueue.pop_front();
                    checkOutput("sb_wb_pc", pc, sbItem.pc);
                    checkOutput("sb_wb_instr", instr, sbItem.word);
                    checkOutput("sb_wb_rf_we", 32'(rf_we), 32'(sbItem.rfWe));
                end
            end else begin
                checkOutput("rf_we_outside_wb", 32'(rf_we), 32'd0);
            end
        end
    end

    // Runs one legal instruction starting from a FETCH cycle, with run held high.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] cycles;
        logic [31:0] startPc;
        cycles  = 0;
        startPc = modelPc;
        checkOutput("vec_fetch_state", 32'(state), 32'd1);
        checkOutput("vec_fetch_addr", imem_addr, modelPc);
        ctl_reg_write_en = 1'b1;
        imem_ack         = 1'b0;
        imem_rdata       = 32'hDEAD_BEEF;
        for (int i = 0; i < v.ackWait; i++) begin
            @(negedge clk);
            cycles++;
            checkOutput("wait_state", 32'(state), 32'd1);
            checkOutput("wait_req", 32'(imem_req), 32'd1);
            checkOutput("wait_addr", imem_addr, startPc);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.word;
        sbQueue.push_back('{modelPc, v.word, v.ctlWe});
        @(negedge clk);
        cycles++;
        checkOutput("dec_state", 32'(state), 32'd2);
        checkOutput("dec_instr", instr, v.word);
        imem_ack         = 1'b0;
        imem_rdata       = 32'hFFFF_FFFF;
        ctl_reg_write_en = v.ctlWe;
        @(negedge clk);
        cycles++;
        checkOutput("exec_state", 32'(state), 32'd3);
        @(negedge clk);
        cycles++;
        @(negedge clk);
        cycles++;
        modelPc      = modelPc + 32'd4;
        modelRetired = modelRetired + 32'd1;
        checkOutput("next_state", 32'(state), 32'd1);
        checkOutput("next_pc", pc, modelPc);
        checkOutput("next_addr", imem_addr, modelPc);
        checkOutput("next_retired", retired, modelRetired);
        checkOutput("latency", cycles, 32'(4 + v.ackWait));
    endtask

    initial begin
        vecs[0] = '{32'h0010_0093, 0, 1'b1};
        vecs[1] = '{32'h0020_81B3, 3, 1'b1};
        vecs[2] = '{32'h0000_0013, 0, 1'b0};
        vecs[3] = '{32'h4020_8233, 1, 1'b1};
        vecs[4] = '{32'h0FF0_F093, 2, 1'b0};

        rst_n            = 1'b0;
        w_rst_n          = 1'b0;
        w_run            = 1'b0;
        run              = 1'b0;
        imem_ack         = 1'b0;
        imem_rdata       = 32'h0;
        ctl_reg_write_en = 1'b0;
        #12;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_retired", retired, 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI x1,x0,5 with ack tied high: exact state walk 1,2,3,4,1.
        run              = 1'b1;
        imem_ack         = 1'b1;
        imem_rdata       = 32'h0050_0093;
        ctl_reg_write_en = 1'b1;
        sbQueue.push_back('{32'h0, 32'h0050_0093, 1'b1});
        @(negedge clk);
        checkOutput("t1_fetch", 32'(state), 32'd1);
        checkOutput("t1_req", 32'(imem_req), 32'd1);
        checkOutput("t1_addr", imem_addr, 32'h0);
        @(negedge clk);
        checkOutput("t1_decode", 32'(state), 32'd2);
        @(negedge clk);
        checkOutput("t1_exec", 32'(state), 32'd3);
        @(negedge clk);
        checkOutput("t1_wb", 32'(state), 32'd4);
        checkOutput("t1_rf_we", 32'(rf_we), 32'd1);
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("t1_refetch", 32'(state), 32'd1);
        checkOutput("t1_pc", pc, 32'd4);
        checkOutput("t1_retired", retired, 32'd1);
        checkOutput("t1_addr4", imem_addr, 32'd4);
        modelPc      = 32'd4;
        modelRetired = 32'd1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // run dropped in EXEC: instruction still retires, then IDLE ignores ack.
        imem_ack         = 1'b1;
        imem_rdata       = 32'h00A0_0113;
        ctl_reg_write_en = 1'b1;
        sbQueue.push_back('{modelPc, 32'h00A0_0113, 1'b1});
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checkOutput("rd_exec", 32'(state), 32'd3);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        modelPc      = modelPc + 32'd4;
        modelRetired = modelRetired + 32'd1;
        checkOutput("rd_idle", 32'(state), 32'd0);
        checkOutput("rd_pc", pc, modelPc);
        checkOutput("rd_retired", retired, modelRetired);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0003;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rd_idle_hold", 32'(state), 32'd0);
            checkOutput("rd_idle_instr", instr, 32'h00A0_0113);
            checkOutput("rd_idle_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        run      = 1'b1;
        @(negedge clk);
        checkOutput("rd_resume", 32'(state), 32'd1);
        checkOutput("rd_resume_addr", imem_addr, modelPc);

        // Illegal opcode (LB) traps and nothing but reset leaves HALT.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0003;
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("il_decode", 32'(state), 32'd2);
        @(negedge clk);
        checkOutput("il_halt", 32'(state), 32'd5);
        checkOutput("il_halted", 32'(halted), 32'd1);
        checkOutput("il_pc", pc, modelPc);
        checkOutput("il_retired", retired, modelRetired);
        checkOutput("il_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run        = i[0];
            imem_ack   = 1'b1;
            imem_rdata = 32'h0050_0093;
            @(negedge clk);
            checkOutput("il_stay", 32'(state), 32'd5);
            checkOutput("il_instr", instr, 32'h0000_0003);
            checkOutput("il_pc_hold", pc, modelPc);
            checkOutput("il_ret_hold", retired, modelRetired);
        end
        imem_ack = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("il_rst_state", 32'(state), 32'd0);
        checkOutput("il_rst_halted", 32'(halted), 32'd0);

        // Asynchronous reset between edges while FETCH is waiting.
        @(negedge clk);
        rst_n        = 1'b1;
        run          = 1'b1;
        modelPc      = 32'h0;
        modelRetired = 32'h0;
        @(negedge clk);
        applyStimulus('{32'h0050_0093, 0, 1'b1});
        imem_ack = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("ar_pre_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_req", 32'(imem_req), 32'd0);
        checkOutput("ar_state", 32'(state), 32'd0);
        checkOutput("ar_pc", pc, 32'h0);
        checkOutput("ar_instr", instr, 32'h0000_0013);
        checkOutput("ar_retired", retired, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        run        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ar_late_state", 32'(state), 32'd0);
            checkOutput("ar_late_instr", instr, 32'h0000_0013);
        end
        imem_ack = 1'b0;

        // Wrap instance: pc wraps past 2^32, 4-bit retired wraps after 16.
        @(negedge clk);
        w_rst_n = 1'b1;
        w_run   = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("wr_state1", 32'(w_state), 32'd1);
        checkOutput("wr_pc1", w_pc, 32'h0);
        checkOutput("wr_ret1", 32'(w_retired), 32'd1);
        repeat (56) @(negedge clk);
        checkOutput("wr_ret15", 32'(w_retired), 32'd15);
        checkOutput("wr_pc15", w_pc, 32'h38);
        repeat (4) @(negedge clk);
        checkOutput("wr_ret16", 32'(w_retired), 32'd0);
        checkOutput("wr_pc16", w_pc, 32'h3C);
        w_run = 1'b0;

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
